// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the data-DRAM port arbiter.
package dram_arb_pkg;

   typedef enum logic {ARB, DBG_LOCK} arb_state_t;
   typedef enum logic {REQ_CPU, REQ_DBG} req_id_t;

   localparam int unsigned STARVE_LIMIT_DEF = 8;
   localparam int unsigned LOCK_MAX_DEF     = 16;

   localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter; clear and increment together load 1 (restart counting this cycle).
module arb_sat_counter #(
   parameter int unsigned W   = 4,
   parameter int unsigned MAX = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= inc ? W'(1) : '0;
      else if (inc && cnt != MAX_V)
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/dram_port_arbiter.sv
// Arbitrates the single-port data DRAM between the CPU MEM stage and the debug/loader port,
// with starvation relief, bounded debug locking and one-cycle read response tagging.
module dram_port_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int unsigned LOCK_MAX     = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [3:0]        cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [31:0]       cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_lock,
   input  logic [3:0]        dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [31:0]       dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [31:0]       dbg_rdata,
   output logic [ADDR_W-1:0] mem_a,
   output logic [3:0]        mem_we,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_spo
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   localparam int unsigned LW = $clog2(LOCK_MAX + 1);

   arb_state_t    state_q, state_d;
   logic          cpu_prio_q, cpu_prio_d;
   logic [SW-1:0] starve_cnt;
   logic [LW-1:0] lock_cnt;
   logic          starved, lock_full;
   logic          cpu_win, dbg_win, enter_lock, any_win, rd_issue;
   req_id_t       winner;
   logic          cpu_rvalid_q, dbg_rvalid_q;

   assign starved   = (starve_cnt == SW'(STARVE_LIMIT));
   assign lock_full = (lock_cnt == LW'(LOCK_MAX));

   always_comb begin
      state_d    = state_q;
      cpu_prio_d = 1'b0;
      cpu_win    = 1'b0;
      dbg_win    = 1'b0;
      enter_lock = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            ARB: begin
               // cpu_prio_q marks the first cycle after a forced release
               if (dbg_req && (!cpu_req || (starved && !cpu_prio_q)))
                  dbg_win = 1'b1;
               else
                  cpu_win = cpu_req;
               if (dbg_win && dbg_lock && !cpu_prio_q) begin
                  enter_lock = 1'b1;
                  state_d    = DBG_LOCK;
               end
            end
            DBG_LOCK: begin
               dbg_win = dbg_req;
               if (lock_full) begin
                  state_d    = ARB;
                  cpu_prio_d = 1'b1;
               end else if (!dbg_lock) begin
                  state_d = ARB;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ARB;
         cpu_prio_q   <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_prio_q   <= cpu_prio_d;
         cpu_rvalid_q <= rd_issue && (winner == REQ_CPU);
         dbg_rvalid_q <= rd_issue && (winner == REQ_DBG);
      end
   end

   arb_sat_counter #(.W(SW), .MAX(STARVE_LIMIT)) u_starve_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state_q == DBG_LOCK) || !dbg_req || dbg_win || cpu_prio_q),
      .inc   (dbg_req && cpu_win && !cpu_prio_q),
      .cnt   (starve_cnt)
   );

   arb_sat_counter #(.W(LW), .MAX(LOCK_MAX)) u_lock_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == ARB),
      .inc   (enter_lock || (state_q == DBG_LOCK)),
      .cnt   (lock_cnt)
   );

   assign any_win = cpu_win || dbg_win;
   assign winner  = dbg_win ? REQ_DBG : REQ_CPU;

   always_comb begin
      mem_a   = '0;
      mem_we  = WE_NONE;
      mem_din = '0;
      if (any_win) begin
         unique case (winner)
            REQ_CPU: begin
               mem_a   = cpu_addr;
               mem_we  = cpu_we;
               mem_din = cpu_wdata;
            end
            REQ_DBG: begin
               mem_a   = dbg_addr;
               mem_we  = dbg_we;
               mem_din = dbg_wdata;
            end
         endcase
      end
   end

   assign rd_issue = any_win && (mem_we == WE_NONE);

   assign cpu_gnt    = cpu_win;
   assign dbg_gnt    = dbg_win;
   assign cpu_stall  = cpu_req && !cpu_win;
   assign cpu_rvalid = cpu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_rdata  = cpu_rvalid_q ? mem_spo : '0;
   assign dbg_rdata  = dbg_rvalid_q ? mem_spo : '0;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: a rule-level reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_dram_port_arbiter;

   localparam int unsigned AW     = 16;
   localparam int          STARVE = 8;
   localparam int          LMAX   = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cpu_req, dbg_req, dbg_lock;
   logic [3:0]    cpu_we, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [31:0]   cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0]   cpu_rdata, dbg_rdata;
   logic [AW-1:0] mem_a;
   logic [3:0]    mem_we;
   logic [31:0]   mem_din;
   logic [31:0]   mem_spo = '0;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dram_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(STARVE), .LOCK_MAX(LMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din), .mem_spo(mem_spo)
   );

   // DRAM macro stand-in and an independent reference copy of its contents
   logic [31:0] dram    [65536];
   logic [31:0] ref_mem [65536];

   initial begin
      for (int i = 0; i < 65536; i++) begin
         dram[i]    = '0;
         ref_mem[i] = '0;
      end
      dram[16'h10] = 32'hDEADBEEF; ref_mem[16'h10] = 32'hDEADBEEF;
      dram[16'h20] = 32'h12345678; ref_mem[16'h20] = 32'h12345678;
   end

   always @(posedge clk) begin
      mem_spo <= dram[mem_a];
      for (int b = 0; b < 4; b++)
         if (mem_we[b]) dram[mem_a][8*b +: 8] <= mem_din[8*b +: 8];
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state: lock ownership, consecutive debug losses, locked-cycle count,
   // post-timeout CPU priority, and the read responses owed next cycle.
   bit          m_locked = 0;
   int          m_lost   = 0;
   int          m_held   = 0;
   bit          m_after  = 0;
   bit          p_cv = 0, p_dv = 0;
   logic [31:0] p_cd = '0, p_dd = '0;

   always @(negedge clk) begin : compare
      bit            cw, dw;
      logic [AW-1:0] ea;
      logic [3:0]    ewe;
      logic [31:0]   ed;
      cw = 0;
      dw = 0;
      if (rst_n) begin
         if (m_locked) dw = dbg_req;
         else if (m_after) begin
            cw = cpu_req;
            dw = dbg_req && !cpu_req;
         end else if (dbg_req && (!cpu_req || m_lost >= STARVE)) dw = 1;
         else cw = cpu_req;
      end
      ea  = cw ? cpu_addr  : dw ? dbg_addr  : '0;
      ewe = cw ? cpu_we    : dw ? dbg_we    : 4'h0;
      ed  = cw ? cpu_wdata : dw ? dbg_wdata : '0;

      chk1 ("m_cpu_gnt",   cpu_gnt,   cw);
      chk1 ("m_dbg_gnt",   dbg_gnt,   dw);
      chk1 ("m_cpu_stall", cpu_stall, cpu_req && !cw);
      chk32("m_mem_a",     32'(mem_a),  32'(ea));
      chk32("m_mem_we",    32'(mem_we), 32'(ewe));
      chk32("m_mem_din",   mem_din,   ed);
      if (rst_n) begin
         chk1 ("m_cpu_rvalid", cpu_rvalid, p_cv);
         chk1 ("m_dbg_rvalid", dbg_rvalid, p_dv);
         chk32("m_cpu_rdata",  cpu_rdata,  p_cv ? p_cd : 32'h0);
         chk32("m_dbg_rdata",  dbg_rdata,  p_dv ? p_dd : 32'h0);
      end

      if (!rst_n) begin
         m_locked = 0; m_lost = 0; m_held = 0; m_after = 0;
         p_cv = 0; p_dv = 0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (ewe[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
         p_cv = cw && (cpu_we == 4'h0);
         p_dv = dw && (dbg_we == 4'h0);
         p_cd = ref_mem[cpu_addr];
         p_dd = ref_mem[dbg_addr];
         if (m_locked) begin
            m_held++;
            m_lost = 0;
            if (m_held >= LMAX) begin
               m_locked = 0;
               m_after  = 1;
            end else if (!dbg_lock) m_locked = 0;
         end else begin
            if (m_after || !dbg_req || dw) m_lost = 0;
            else if (cw && m_lost < STARVE) m_lost++;
            if (dw && dbg_lock && !m_after) begin
               m_locked = 1;
               m_held   = 0;
            end
            m_after = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic r, input logic [3:0] we, input logic [AW-1:0] a,
                          input logic [31:0] d);
      cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dbg(input logic r, input logic l, input logic [3:0] we,
                          input logic [AW-1:0] a, input logic [31:0] d);
      dbg_req = r; dbg_lock = l; dbg_we = we; dbg_addr = a; dbg_wdata = d;
   endtask

   logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

   initial begin
      int  n;
      bit  done;
      rst_n = 1'b0;
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      tick();

      // reset with both requesting writes: no grant, no write strobe
      set_cpu(1'b1, 4'hF, 16'h10, 32'hFFFFFFFF);
      set_dbg(1'b1, 1'b0, 4'hF, 16'h20, 32'hFFFFFFFF);
      tick();
      #2;
      chk1 ("rst_cpu_gnt", cpu_gnt, 1'b0);
      chk1 ("rst_dbg_gnt", dbg_gnt, 1'b0);
      chk32("rst_mem_we",  32'(mem_we), 32'h0);
      tick();
      rst_n = 1'b1;
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      #2;
      chk1("post_rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk1("post_rst_dbg_rvalid", dbg_rvalid, 1'b0);
      tick();

      // CPU read alone
      set_cpu(1'b1, 4'h0, 16'h10, '0);
      #2;
      chk1 ("rd_cpu_gnt", cpu_gnt, 1'b1);
      chk32("rd_mem_a",   32'(mem_a), 32'h10);
      tick();
      set_cpu(1'b0, 4'h0, '0, '0);
      #2;
      chk1 ("rd_cpu_rvalid", cpu_rvalid, 1'b1);
      chk32("rd_cpu_rdata",  cpu_rdata, 32'hDEADBEEF);
      chk1 ("rd_dbg_rvalid", dbg_rvalid, 1'b0);
      tick();

      // starvation: CPU 8 grants, debug in cycle 9, CPU again in cycle 10
      set_cpu(1'b1, 4'h0, 16'h10, '0);
      set_dbg(1'b1, 1'b0, 4'h0, 16'h20, '0);
      for (int i = 1; i <= 10; i++) begin
         #2;
         if (i == 9) begin
            chk1("starve_dbg_gnt",   dbg_gnt,   1'b1);
            chk1("starve_cpu_stall", cpu_stall, 1'b1);
         end else begin
            chk1("starve_cpu_gnt", cpu_gnt, 1'b1);
         end
         if (i == 10) begin
            chk1 ("starve_dbg_rvalid", dbg_rvalid, 1'b1);
            chk32("starve_dbg_rdata",  dbg_rdata,  32'h12345678);
            chk1 ("starve_cpu_rvalid", cpu_rvalid, 1'b0);
         end
         tick();
      end
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      tick();

      // locked burst: debug wins after starving, then holds the port for 4 writes
      set_cpu(1'b1, 4'h0, 16'h10, '0);
      set_dbg(1'b1, 1'b1, 4'hF, 16'h0, vals[0]);
      for (int i = 1; i <= 8; i++) begin
         #2;
         chk1("burst_pre_cpu_gnt", cpu_gnt, 1'b1);
         tick();
      end
      for (int k = 0; k < 4; k++) begin
         set_dbg(1'b1, k < 3, 4'hF, AW'(k), vals[k]);
         #2;
         chk1("burst_cpu_stall", cpu_stall, 1'b1);
         chk1("burst_dbg_gnt",   dbg_gnt,   1'b1);
         tick();
      end
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      #2;
      chk1("burst_cpu_back", cpu_gnt, 1'b1);
      tick();
      for (int k = 0; k <= 4; k++) begin
         if (k < 4) set_cpu(1'b1, 4'h0, AW'(k), '0);
         else       set_cpu(1'b0, 4'h0, '0, '0);
         #2;
         if (k > 0) chk32("burst_readback", cpu_rdata, vals[k-1]);
         tick();
      end

      // lock timeout: 16 locked cycles, then CPU granted
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b1, 1'b1, 4'h0, 16'h20, '0);
      #2;
      chk1("lto_dbg_gnt", dbg_gnt, 1'b1);
      tick();
      set_cpu(1'b1, 4'h0, 16'h10, '0);
      n = 0;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         #2;
         if (cpu_gnt) done = 1;
         else n++;
         tick();
      end
      chk1 ("lto_released", done, 1'b1);
      chk32("lto_locked_cycles", n, 32'd16);
      for (int i = 0; i < 12; i++) tick();
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      tick();
      tick();

      // reset mid-lock with a read outstanding
      set_dbg(1'b1, 1'b1, 4'h0, 16'h20, '0);
      tick();
      set_cpu(1'b1, 4'h0, 16'h10, '0);
      #2;
      chk1("rml_dbg_gnt", dbg_gnt, 1'b1);
      tick();
      rst_n = 1'b0;
      set_dbg(1'b1, 1'b1, 4'hF, 16'h20, 32'hFFFFFFFF);
      #2;
      chk1 ("rml_cpu_gnt", cpu_gnt, 1'b0);
      chk1 ("rml_dbg_gnt_rst", dbg_gnt, 1'b0);
      chk32("rml_mem_we", 32'(mem_we), 32'h0);
      tick();
      rst_n = 1'b1;
      set_dbg(1'b1, 1'b1, 4'h0, 16'h20, '0);
      #2;
      chk1("rml_cpu_wins",   cpu_gnt,    1'b1);
      chk1("rml_dbg_lose",   dbg_gnt,    1'b0);
      chk1("rml_dbg_rvalid", dbg_rvalid, 1'b0);
      chk1("rml_cpu_rvalid", cpu_rvalid, 1'b0);
      tick();
      set_cpu(1'b0, 4'h0, '0, '0);
      set_dbg(1'b0, 1'b0, 4'h0, '0, '0);
      tick();

      // byte strobes: low half-word only
      set_cpu(1'b1, 4'b0011, 16'h20, 32'hAABBCCDD);
      #2;
      chk32("bs_mem_we",  32'(mem_we), 32'h3);
      chk32("bs_mem_din", mem_din, 32'hAABBCCDD);
      tick();
      set_cpu(1'b1, 4'h0, 16'h20, '0);
      tick();
      set_cpu(1'b0, 4'h0, '0, '0);
      #2;
      chk32("bs_readback", cpu_rdata, 32'h1234CCDD);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
Arbitrates the single-port synchronous data DRAM between two requesters: the CPU MEM-stage data port and a debug/loader port used for program load and memory inspection. It sits between the MEM stage and the DRAM macro. It returns a stall to the hazard logic whenever the CPU loses arbitration. It also routes the one-cycle-latency read data back to whichever requester issued the read.

Parameters:
ADDR_W, 16, word-address width driven to DRAM
STARVE_LIMIT, 8, consecutive lost cycles after which the debug port wins one grant
LOCK_MAX, 16, maximum cycles the debug port may hold a lock

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request
cpu_we  in  4  CPU byte write strobes; 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  32  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the pipeline
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  32  CPU read data
dbg_req  in  1  debug access request
dbg_lock  in  1  request exclusive ownership after the current grant
dbg_we  in  4  debug byte write strobes; 0 = read
dbg_addr  in  ADDR_W  debug word address
dbg_wdata  in  32  debug write data
dbg_gnt  out  1  debug access accepted this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  32  debug read data
mem_a  out  ADDR_W  DRAM address
mem_we  out  4  DRAM byte write enables
mem_din  out  32  DRAM write data
mem_spo  in  32  DRAM read data, valid one cycle after the address

Behaviour:
- Reset is synchronous, active-low on rst_n, clock clk. While rst_n=0:
  - Both gnt outputs are forced to 0 combinationally, and mem_we=0.
  - On the reset edge: state=ARB, starve_cnt=0, lock_cnt=0, rvalid registers=0.
  - Any pending read response is dropped.
- Grants are combinational, issued in the same cycle as the request. At most one gnt is high per cycle.
- Winner routing: the winner's addr/we/wdata drive mem_a/mem_we/mem_din. With no winner: mem_a=0, mem_we=0, mem_din=0.
- Read response:
  - A granted access with we==0 sets that requester's rvalid register; it is high for exactly the next cycle.
  - The matching rdata = mem_spo in that cycle; the other requester's rdata = 0.
  - Writes produce no response. Back-to-back reads give back-to-back rvalid.
- FSM states: ARB, DBG_LOCK.
- ARB:
  - CPU wins by default when both request.
  - The debug port wins when starve_cnt == STARVE_LIMIT, or when cpu_req=0.
  - starve_cnt increments (saturating) each cycle dbg_req=1 and the CPU wins. It clears to 0 when dbg is granted or dbg_req=0.
  - Transition to DBG_LOCK when dbg is granted with dbg_lock=1; lock_cnt is set to 1.
- DBG_LOCK:
  - Only the debug port can be granted; cpu_gnt=0, so cpu_stall=cpu_req.
  - lock_cnt increments each cycle.
  - Return to ARB on the edge where dbg_lock=0 is sampled. A dbg access in that cycle is still granted.
  - Return to ARB on the edge where lock_cnt == LOCK_MAX; the forced release takes priority.
  - After a forced release, the first ARB cycle gives CPU priority regardless of starve_cnt, and starve_cnt is cleared.
- While dbg_lock stays high after a forced release, the port may re-lock only after it wins a normal ARB grant.
- Simultaneous reads to the same address are serialized; each requester gets its own rvalid.
- cpu_stall is independent of rvalid. The load-use wait for read data remains the hazard unit's responsibility.

Decomposition:
- Package dram_arb_pkg holds:
  - arb_state_t enum {ARB, DBG_LOCK}
  - requester id enum {REQ_CPU, REQ_DBG}
  - defaults for STARVE_LIMIT and LOCK_MAX
  - the WE_NONE = 4'b0000 constant
- One sub-module, arb_sat_counter: a saturating counter with clear, increment and width parameter. It is instantiated for starve_cnt and lock_cnt.
- The top level holds the FSM, grant logic, muxing and response tagging.

Test Plan:
- CPU read alone: cpu_req=1, we=0, addr=0x0010, DRAM[0x10]=0xDEADBEEF -> cpu_gnt=1 same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- Starvation (STARVE_LIMIT=8): both request reads continuously from cycle 1 -> CPU granted cycles 1-8; dbg_gnt=1 and cpu_stall=1 in cycle 9; CPU granted again in cycle 10.
- Locked burst: dbg writes 0x11,0x22,0x33,0x44 to addr 0x0..0x3 with dbg_lock=1, dropping lock on the last write, while cpu_req=1 -> cpu_stall=1 for all 4 cycles; CPU granted in cycle 5; readback returns the four values.
- Lock timeout (LOCK_MAX=16): dbg_lock held high with cpu_req=1 -> forced return to ARB after 16 locked cycles; cpu_gnt=1 in the next cycle.
- Reset mid-lock: rst_n=0 for 1 cycle during DBG_LOCK with a pending read -> gnt=0 and mem_we=0 during reset; state=ARB, rvalid=0 afterwards; CPU wins the first contested cycle.
- Byte strobes: cpu_we=4'b0011, wdata=0xAABBCCDD over 0x12345678 -> mem_we=4'b0011; readback gives 0x1234CCDD.
